// File: rtl/pc_redirect_ctrl_if.sv
// Branch-redirect bus from the execute-stage branch logic to the fetch PC controller.
// The master (EX stage) drives the redirect request; the slave (fetch) consumes it.
interface pc_redirect_ctrl_if;
  logic        PcSel;
  logic        Jal;
  logic        Halt;
  logic [31:0] BrPC;

  modport master (output PcSel, output Jal, output Halt, output BrPC);
  modport slave  (input  PcSel, input  Jal, input  Halt, input  BrPC);
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC register with registered redirect, flush, misalign and halt outputs.
// Optional saturating redirect counter is enabled by defining PC_REDIRECT_CNT_EN.
module pc_redirect_ctrl #(
  parameter int          PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stall,
  pc_redirect_ctrl_if.slave   s_redirect,
  output logic [PC_W-1:0]     o_pc,
  output logic                o_pc_valid,
  output logic                o_flush_if_id,
  output logic                o_flush_id_ex,
  output logic                o_misalign,
  output logic                o_halted,
  output logic [15:0]         o_redirect_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALTED} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic            r_pc_valid;
  logic            r_flush;
  logic            r_misalign;
  logic            r_halted;
  logic            w_flush;
  logic            w_misalign;
  logic            w_cnt_inc;
  logic            w_unused;

  assign w_pc_inc = r_pc + PC_W'(4);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_flush      = 1'b0;
    w_misalign   = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_BOOT: w_next_state = S_RUN;
      S_RUN: begin
        if (s_redirect.Halt) begin
          w_next_state = S_HALTED;
          w_flush      = 1'b1;
        end else if (s_redirect.PcSel || s_redirect.Jal) begin
          // Redirect beats Stall: the stalled instruction is younger and gets squashed.
          w_next_state = S_FLUSH;
          w_next_pc    = {s_redirect.BrPC[PC_W-1:2], 2'b00};
          w_flush      = 1'b1;
          w_misalign   = |s_redirect.BrPC[1:0];
          w_cnt_inc    = 1'b1;
        end else if (!i_stall) begin
          w_next_pc = w_pc_inc;
        end
      end
      S_FLUSH: begin
        w_next_state = S_RUN;
        if (!i_stall) w_next_pc = w_pc_inc;
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_BOOT;
      r_pc       <= PC_W'(RESET_PC);
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_misalign <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_pc_valid <= (w_next_state == S_RUN) || (w_next_state == S_FLUSH);
      r_flush    <= w_flush;
      r_misalign <= w_misalign;
      r_halted   <= (w_next_state == S_HALTED);
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_valid    = r_pc_valid;
  assign o_flush_if_id = r_flush;
  assign o_flush_id_ex = r_flush;
  assign o_misalign    = r_misalign;
  assign o_halted      = r_halted;

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= 16'h0000;
    end else if (w_cnt_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_redirect_count = r_cnt;
  assign w_unused         = ^s_redirect.BrPC;
`else
  assign o_redirect_count = 16'h0000;
  assign w_unused         = ^{s_redirect.BrPC, w_cnt_inc};
`endif

endmodule
